// File: rtl/cpu_regfile_pkg.sv
// Shared types and helpers for the parametrised CPU register block.
// Holds the PC operation encoding, default sizes and offset sign extension.
package cpu_regfile_pkg;

    localparam int DW_DEF        = 8;
    localparam int NREGS_DEF     = 2;
    localparam int SELW_DEF      = 1;
    localparam int STK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_REL,
        PC_LOAD,
        PC_CALL,
        PC_RET
    } pc_op_e;

    // Only one PC action per cycle: return beats call beats load beats relative beats increment.
    function automatic pc_op_e pc_op_decode(input logic ret, input logic call,
                                            input logic load, input logic rel,
                                            input logic inc);
        if (ret)  return PC_RET;
        if (call) return PC_CALL;
        if (load) return PC_LOAD;
        if (rel)  return PC_REL;
        if (inc)  return PC_INC;
        return PC_HOLD;
    endfunction

    function automatic logic [63:0] sext_off(input logic [63:0] val, input int width);
        logic signed [63:0] tmp;
        tmp = $signed(val << (64 - width));
        return tmp >>> (64 - width);
    endfunction

endpackage

// File: rtl/cpu_ret_stack.sv
// Parametrised LIFO holding PC return addresses.
// Pops take precedence over pushes; overflow/underflow flagging belongs to the parent.
module cpu_ret_stack #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DW-1:0]                push_data,
    output logic [DW-1:0]                top,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int DPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0]  mem [DEPTH];
    logic [DPW-1:0] cnt;
    logic [AW-1:0]  top_idx;
    logic [AW-1:0]  wr_idx;

    assign top_idx = AW'(cnt - DPW'(1));
    assign wr_idx  = AW'(cnt);
    assign full    = (cnt == DPW'(DEPTH));
    assign empty   = (cnt == '0);
    assign depth   = cnt;
    assign top     = empty ? '0 : mem[top_idx];

    // Entries are not cleared on reset; the count alone defines what is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (pop && !empty) begin
            cnt <= cnt - DPW'(1);
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            cnt         <= cnt + DPW'(1);
        end
    end

endmodule

// File: rtl/cpu_regfile_p.sv
// Parametrised GPR file, memory address register rM and program counter with return stack.
// Optional macro CPU_REGFILE_P_BYPASS_EN forwards same-cycle GPR writes to the read ports.
module cpu_regfile_p
    import cpu_regfile_pkg::*;
#(
    parameter int DW        = DW_DEF,
    parameter int NREGS     = NREGS_DEF,
    parameter int SELW      = SELW_DEF,
    parameter int STK_DEPTH = STK_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [SELW-1:0]                  wr_sel,
    input  logic [DW-1:0]                    wr_data,
    input  logic [SELW-1:0]                  rd0_sel,
    output logic [DW-1:0]                    rd0_data,
    input  logic [SELW-1:0]                  rd1_sel,
    output logic [DW-1:0]                    rd1_data,
    input  logic                             rM_we,
    input  logic [DW-1:0]                    rM_in,
    output logic [DW-1:0]                    rM_out,
    input  logic                             pc_inc,
    input  logic                             pc_load,
    input  logic                             pc_rel,
    input  logic                             pc_call,
    input  logic                             pc_ret,
    input  logic [DW-1:0]                    pc_target,
    output logic [DW-1:0]                    rP_out,
    output logic [$clog2(STK_DEPTH+1)-1:0]   stk_depth,
    output logic                             stk_ovf,
    output logic                             stk_unf
);

    logic [DW-1:0] gpr [NREGS];
    logic [DW-1:0] rm_q;
    logic [DW-1:0] rp_q;
    logic [DW-1:0] rp_nxt;
    logic [DW-1:0] ret_addr;
    logic [DW-1:0] stk_top;
    logic          stk_full;
    logic          stk_empty;
    logic          push;
    logic          pop;
    logic          ovf_q;
    logic          unf_q;
    pc_op_e        op;

    assign op       = pc_op_decode(pc_ret, pc_call, pc_load, pc_rel, pc_inc);
    assign push     = (op == PC_CALL) && !stk_full;
    assign pop      = (op == PC_RET) && !stk_empty;
    assign ret_addr = rp_q + DW'(1);

    assign rM_out  = rm_q;
    assign rP_out  = rp_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

    cpu_ret_stack #(
        .DW    (DW),
        .DEPTH (STK_DEPTH)
    ) u_ret_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (ret_addr),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty),
        .depth     (stk_depth)
    );

    // A call on a full stack still jumps; a return on an empty stack holds the PC.
    always_comb begin
        rp_nxt = rp_q;
        case (op)
            PC_INC:  rp_nxt = rp_q + DW'(1);
            PC_REL:  rp_nxt = DW'(64'(rp_q) + sext_off(64'(pc_target), DW));
            PC_LOAD: rp_nxt = pc_target;
            PC_CALL: rp_nxt = pc_target;
            PC_RET:  if (!stk_empty) rp_nxt = stk_top;
            default: rp_nxt = rp_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rp_q  <= '0;
            rm_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
        end else begin
            rp_q <= rp_nxt;
            if (rM_we) rm_q <= rM_in;
            if (op == PC_CALL && stk_full) ovf_q <= 1'b1;
            if (op == PC_RET && stk_empty) unf_q <= 1'b1;
            for (int i = 0; i < NREGS; i++) begin
                if (wr_en && wr_sel == SELW'(i)) gpr[i] <= wr_data;
            end
        end
    end

    // Selects with no matching register fall through to zero.
    always_comb begin
        rd0_data = '0;
        rd1_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd0_sel == SELW'(i)) rd0_data = gpr[i];
            if (rd1_sel == SELW'(i)) rd1_data = gpr[i];
`ifdef CPU_REGFILE_P_BYPASS_EN
            if (wr_en && wr_sel == SELW'(i)) begin
                if (rd0_sel == SELW'(i)) rd0_data = wr_data;
                if (rd1_sel == SELW'(i)) rd1_data = wr_data;
            end
`else
`endif
        end
    end

endmodule
